// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control with trap, mret, jump and branch redirects.
// pc/epc/misalign are registered (one-edge latency); next_pc and pc_plus4 are combinational.
module pc_sequencer #(
  parameter int          OPD_WIDTH    = 32,
  parameter int          PC_WIDTH     = 32,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned TRAP_VECTOR  = 'h100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch,
  input  logic                 jump,
  input  logic [OPD_WIDTH-1:0] comp_result,
  input  logic [OPD_WIDTH-1:0] alu_result,
  input  logic                 trap,
  input  logic                 mret,
  input  logic                 halt,
  input  logic                 resume,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_plus4,
  output logic [PC_WIDTH-1:0]  next_pc,
  output logic [PC_WIDTH-1:0]  epc,
  output logic                 misalign,
  output logic                 running
);

  localparam logic [PC_WIDTH-1:0] LP_RESET_VEC = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] LP_TRAP_VEC  = PC_WIDTH'(TRAP_VECTOR);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_epc;
  logic                r_misalign;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic [PC_WIDTH-1:0] w_epc_nxt;
  logic                w_misalign_nxt;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic [PC_WIDTH-1:0] w_target_raw;
  logic [PC_WIDTH-1:0] w_jump_tgt;
  logic [PC_WIDTH-1:0] w_sel_tgt;
  logic                w_taken;
  logic                w_tgt_misaligned;

  generate
    if (OPD_WIDTH >= PC_WIDTH) begin : g_tgt_trunc
      assign w_target_raw = alu_result[PC_WIDTH-1:0];
      if (OPD_WIDTH > PC_WIDTH) begin : g_alu_hi
        logic w_unused_alu_hi;
        assign w_unused_alu_hi = ^alu_result[OPD_WIDTH-1:PC_WIDTH];
      end
    end else begin : g_tgt_zext
      assign w_target_raw = {{(PC_WIDTH-OPD_WIDTH){1'b0}}, alu_result};
    end
    if (OPD_WIDTH > 1) begin : g_comp_hi
      logic w_unused_comp_hi;
      assign w_unused_comp_hi = ^comp_result[OPD_WIDTH-1:1];
    end
  endgenerate

  assign w_pc_plus4       = r_pc + PC_WIDTH'(4);
  assign w_taken          = branch & comp_result[0];
  assign w_jump_tgt       = {w_target_raw[PC_WIDTH-1:1], 1'b0};
  // Jump wins over branch, so its target is the one checked for alignment.
  assign w_sel_tgt        = jump ? w_jump_tgt : w_target_raw;
  assign w_tgt_misaligned = (jump | w_taken) & (w_sel_tgt[1:0] != 2'b00);

  always_comb begin
    w_state_nxt    = r_state;
    w_next_pc      = r_pc;
    w_epc_nxt      = r_epc;
    w_misalign_nxt = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_HALT: begin
        if (trap) begin
          w_next_pc   = LP_TRAP_VEC;
          w_epc_nxt   = r_pc;
          w_state_nxt = ST_RUN;
        end else if (resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (trap) begin
          w_next_pc = LP_TRAP_VEC;
          w_epc_nxt = r_pc;
        end else if (w_tgt_misaligned) begin
          w_next_pc      = LP_TRAP_VEC;
          w_epc_nxt      = r_pc;
          w_misalign_nxt = 1'b1;
        end else if (mret) begin
          w_next_pc = r_epc;
        end else if (jump) begin
          w_next_pc = w_jump_tgt;
        end else if (w_taken) begin
          w_next_pc = w_target_raw;
        end else if (!stall) begin
          w_next_pc = w_pc_plus4;
        end
        if (halt && !trap && !w_tgt_misaligned) w_state_nxt = ST_HALT;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
    if (!rst) w_next_pc = LP_RESET_VEC;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= LP_RESET_VEC;
      r_epc      <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_next_pc;
      r_epc      <= w_epc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign next_pc  = w_next_pc;
  assign epc      = r_epc;
  assign misalign = r_misalign;
  assign running  = (r_state == ST_RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: 32-bit instance for control flow, 8-bit instance for wrap-around.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, branch, jump, trap, mret, halt, resume;
  logic [31:0] comp_result, alu_result;
  logic [31:0] pc, pc_plus4, next_pc, epc;
  logic        misalign, running;

  logic        s_rst, s_jump;
  logic [31:0] s_alu;
  logic [7:0]  s_pc, s_pc_plus4, s_next_pc, s_epc;
  logic        s_misalign, s_running;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jump(jump),
    .comp_result(comp_result), .alu_result(alu_result), .trap(trap), .mret(mret),
    .halt(halt), .resume(resume), .pc(pc), .pc_plus4(pc_plus4), .next_pc(next_pc),
    .epc(epc), .misalign(misalign), .running(running)
  );

  pc_sequencer #(.OPD_WIDTH(32), .PC_WIDTH(8), .RESET_VECTOR(0), .TRAP_VECTOR('h80)) dut8 (
    .clk(clk), .rst(s_rst), .stall(1'b0), .branch(1'b0), .jump(s_jump),
    .comp_result(32'h0), .alu_result(s_alu), .trap(1'b0), .mret(1'b0),
    .halt(1'b0), .resume(1'b0), .pc(s_pc), .pc_plus4(s_pc_plus4), .next_pc(s_next_pc),
    .epc(s_epc), .misalign(s_misalign), .running(s_running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; jump = 0; trap = 0; mret = 0; halt = 0; resume = 0;
    comp_result = '0; alu_result = '0;
  endtask

  task automatic test_reset();
    rst = 0; clear_inputs();
    tick();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running got=%b exp=0", running); end
    tests++; if (epc !== 32'h0 || misalign !== 1'b0) begin fails++; $display("FAIL reset_epc_mis epc=%h mis=%b exp 0/0", epc, misalign); end
    trap = 1; alu_result = 32'h44; jump = 1;
    #1;
    tests++; if (next_pc !== 32'h0) begin fails++; $display("FAIL reset_next_pc got=%h exp=%h", next_pc, 32'h0); end
    clear_inputs(); rst = 1;
    #1;
    tests++; if (next_pc !== 32'h0) begin fails++; $display("FAIL boot_hold next_pc got=%h exp=0", next_pc); end
    tick();
    tests++; if (pc !== 32'h0 || running !== 1'b1) begin fails++; $display("FAIL boot_exit pc=%h run=%b exp 0/1", pc, running); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++; if (pc !== 32'(4 * i)) begin fails++; $display("FAIL run_seq pc=%h exp=%h", pc, 32'(4 * i)); end
    end
    tests++; if (pc_plus4 !== 32'h10) begin fails++; $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, 32'h10); end
  endtask

  task automatic test_branch();
    branch = 1; comp_result = 32'h0; alu_result = 32'h30;
    tick();
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL branch_nt pc=%h exp=%h", pc, 32'h10); end
    comp_result = 32'hFFFF_FFFE;
    tick();
    tests++; if (pc !== 32'h14) begin fails++; $display("FAIL branch_bit0 pc=%h exp=%h", pc, 32'h14); end
    comp_result = 32'h1;
    tick();
    tests++; if (pc !== 32'h30) begin fails++; $display("FAIL branch_taken pc=%h exp=%h", pc, 32'h30); end
    clear_inputs();
  endtask

  task automatic test_jump();
    jump = 1; alu_result = 32'h41;
    tick();
    tests++; if (pc !== 32'h40 || misalign !== 1'b0) begin fails++; $display("FAIL jump_bit0 pc=%h mis=%b exp 40/0", pc, misalign); end
    alu_result = 32'h42;
    tick();
    tests++; if (pc !== 32'h100 || epc !== 32'h40) begin fails++; $display("FAIL jump_misalign pc=%h epc=%h exp 100/40", pc, epc); end
    tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL misalign_pulse got=%b exp=1", misalign); end
    clear_inputs();
    tick();
    tests++; if (misalign !== 1'b0 || pc !== 32'h104) begin fails++; $display("FAIL misalign_clear mis=%b pc=%h exp 0/104", misalign, pc); end
    jump = 1; branch = 1; comp_result = 32'h1; alu_result = 32'h21;
    tick();
    tests++; if (pc !== 32'h20 || misalign !== 1'b0) begin fails++; $display("FAIL jump_over_branch pc=%h mis=%b exp 20/0", pc, misalign); end
    clear_inputs();
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pc !== 32'h20) begin fails++; $display("FAIL stall_hold pc=%h exp=%h", pc, 32'h20); end
    end
    trap = 1;
    tick();
    tests++; if (pc !== 32'h100 || epc !== 32'h20) begin fails++; $display("FAIL stall_trap pc=%h epc=%h exp 100/20", pc, epc); end
    clear_inputs();
  endtask

  task automatic test_trap_mret_halt();
    jump = 1; alu_result = 32'h50;
    tick();
    clear_inputs(); trap = 1;
    tick();
    tests++; if (pc !== 32'h100 || epc !== 32'h50) begin fails++; $display("FAIL trap pc=%h epc=%h exp 100/50", pc, epc); end
    clear_inputs();
    tick();
    mret = 1;
    tick();
    tests++; if (pc !== 32'h50 || epc !== 32'h50) begin fails++; $display("FAIL mret pc=%h epc=%h exp 50/50", pc, epc); end
    clear_inputs(); halt = 1;
    tick();
    tests++; if (pc !== 32'h54 || running !== 1'b0) begin fails++; $display("FAIL halt_enter pc=%h run=%b exp 54/0", pc, running); end
    clear_inputs(); jump = 1; alu_result = 32'h80; mret = 1;
    tick(); tick();
    tests++; if (pc !== 32'h54 || running !== 1'b0) begin fails++; $display("FAIL halt_frozen pc=%h run=%b exp 54/0", pc, running); end
    clear_inputs(); resume = 1;
    tick();
    tests++; if (pc !== 32'h54 || running !== 1'b1) begin fails++; $display("FAIL resume pc=%h run=%b exp 54/1", pc, running); end
    clear_inputs();
    tick();
    tests++; if (pc !== 32'h58) begin fails++; $display("FAIL after_resume pc=%h exp=%h", pc, 32'h58); end
    halt = 1;
    tick();
    clear_inputs(); trap = 1;
    tick();
    tests++; if (pc !== 32'h100 || epc !== 32'h5C || running !== 1'b1) begin fails++; $display("FAIL halt_trap pc=%h epc=%h run=%b exp 100/5c/1", pc, epc, running); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_halt();
    halt = 1;
    tick();
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL halt_again run=%b exp=0", running); end
    clear_inputs(); rst = 0; trap = 1; resume = 1;
    tick();
    tests++; if (pc !== 32'h0 || epc !== 32'h0 || running !== 1'b0) begin fails++; $display("FAIL reset_in_halt pc=%h epc=%h run=%b exp 0/0/0", pc, epc, running); end
    clear_inputs(); rst = 1;
    tick();
    tests++; if (pc !== 32'h0 || running !== 1'b1) begin fails++; $display("FAIL reboot pc=%h run=%b exp 0/1", pc, running); end
  endtask

  task automatic test_wrap();
    s_rst = 0; s_jump = 0; s_alu = '0;
    tick();
    s_rst = 1;
    tick();
    s_jump = 1; s_alu = 32'hABCD_00FC;
    tick();
    tests++; if (s_pc !== 8'hFC) begin fails++; $display("FAIL wrap_setup pc=%h exp=fc", s_pc); end
    s_jump = 0;
    #1;
    tests++; if (s_pc_plus4 !== 8'h00) begin fails++; $display("FAIL wrap_plus4 got=%h exp=00", s_pc_plus4); end
    tick();
    tests++; if (s_pc !== 8'h00 || s_running !== 1'b1) begin fails++; $display("FAIL wrap_pc pc=%h run=%b exp 00/1", s_pc, s_running); end
  endtask

  initial begin
    rst = 0; s_rst = 0; s_jump = 0; s_alu = '0;
    clear_inputs();
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_trap_mret_halt();
    test_reset_mid_halt();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
